// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, execute-stage FSM states and default width.
// Imported by the execute stage and by the ALU-control decoder.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_SLL   = 4'h2,
        ALU_SLT   = 4'h3,
        ALU_SLTU  = 4'h4,
        ALU_XOR   = 4'h5,
        ALU_SRA   = 4'h6,
        ALU_SRL   = 4'h7,
        ALU_OR    = 4'h8,
        ALU_AND   = 4'h9,
        ALU_BEQ   = 4'ha,
        ALU_BNE   = 4'hb,
        ALU_BGE   = 4'hc,
        ALU_BGEU  = 4'hd,
        ALU_RSV_E = 4'he,
        ALU_RSV_F = 4'hf
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial shifter: loads an operand, then steps it each cycle until the count is used up.
// Optional macro ALU_SHIFT4_EN enables 4-position steps while at least 4 remain.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [3:0]      op,
    input  logic [SHW-1:0]  shamt,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] data_next,
    output logic            busy_sh,
    output logic            last
);

    logic [XLEN-1:0] shreg_r;
    logic [SHW-1:0]  count_r;
    alu_op_t         op_r;
    logic [SHW-1:0]  step_s;

    // Step size for the current cycle
    always_comb begin
`ifdef ALU_SHIFT4_EN
        if (count_r >= SHW'(3'd4)) begin
            step_s = SHW'(3'd4);
        end else begin
            step_s = SHW'(1'b1);
        end
`else
        step_s = SHW'(1'b1);
`endif
    end

    // Value after this cycle's step; SRA replicates the sign bit
    always_comb begin
        data_next = shreg_r;
        case (op_r)
            ALU_SLL: data_next = shreg_r << step_s;
            ALU_SRL: data_next = shreg_r >> step_s;
            ALU_SRA: data_next = XLEN'($signed(shreg_r) >>> step_s);
            default: data_next = shreg_r;
        endcase
    end

    assign busy_sh = (count_r != {SHW{1'b0}});
    assign last    = busy_sh && (count_r == step_s);

    // Shift register, remaining count and latched op
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {XLEN{1'b0}};
            count_r <= {SHW{1'b0}};
            op_r    <= ALU_ADD;
        end else if (load) begin
            shreg_r <= data_in;
            count_r <= shamt;
            op_r    <= alu_op_t'(op);
        end else if (busy_sh) begin
            shreg_r <= data_next;
            count_r <= count_r - step_s;
        end else begin
            shreg_r <= shreg_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/alu_serial_exec.sv
// Execute stage: single-cycle ALU/branch ops plus serial shifts behind an IDLE/SHIFT/DONE FSM.
// Build option ALU_SHIFT4_EN (in alu_serial_shifter) speeds up long shifts; results are unchanged.
module alu_serial_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      aluControl,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [XLEN-1:0] result,
    output logic            branchTaken,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    state_t          state_r, state_nxt_s;
    alu_op_t         op_s;
    logic [SHW-1:0]  shamt_s;
    logic            launch_shift_s;
    logic            lt_s, ltu_s;
    logic [XLEN-1:0] alu_result_s;
    logic            alu_branch_s, alu_illegal_s;
    logic [XLEN-1:0] sh_data_s;
    logic            sh_busy_s, sh_last_s;
    logic [XLEN-1:0] result_r, result_nxt_s;
    logic            branch_r, branch_nxt_s;
    logic            done_r, done_nxt_s;
    logic            illegal_r, illegal_nxt_s;

    assign op_s           = alu_op_t'(aluControl);
    assign shamt_s        = srcB[SHW-1:0];
    assign launch_shift_s = (state_r == ST_IDLE) && start && is_shift_op(op_s)
                            && (shamt_s != {SHW{1'b0}});
    assign lt_s           = ($signed(srcA) < $signed(srcB));
    assign ltu_s          = (srcA < srcB);

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (launch_shift_s),
        .op        (aluControl),
        .shamt     (shamt_s),
        .data_in   (srcA),
        .data_next (sh_data_s),
        .busy_sh   (sh_busy_s),
        .last      (sh_last_s)
    );

    // Single-cycle datapath; shift codes only get here with a zero amount
    always_comb begin
        alu_result_s  = {XLEN{1'b0}};
        alu_branch_s  = 1'b0;
        alu_illegal_s = 1'b0;
        case (op_s)
            ALU_ADD:   alu_result_s = srcA + srcB;
            ALU_SUB:   alu_result_s = srcA - srcB;
            ALU_SLL,
            ALU_SRA,
            ALU_SRL:   alu_result_s = srcA;
            ALU_SLT: begin
                alu_result_s = {{(XLEN-1){1'b0}}, lt_s};
                alu_branch_s = lt_s;
            end
            ALU_SLTU: begin
                alu_result_s = {{(XLEN-1){1'b0}}, ltu_s};
                alu_branch_s = ltu_s;
            end
            ALU_XOR:   alu_result_s = srcA ^ srcB;
            ALU_OR:    alu_result_s = srcA | srcB;
            ALU_AND:   alu_result_s = srcA & srcB;
            ALU_BEQ:   alu_branch_s = (srcA == srcB);
            ALU_BNE:   alu_branch_s = (srcA != srcB);
            ALU_BGE:   alu_branch_s = !lt_s;
            ALU_BGEU:  alu_branch_s = !ltu_s;
            default:   alu_illegal_s = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = launch_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sh_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output next values: result/branch held between completions, done/illegal pulse
    always_comb begin
        result_nxt_s  = result_r;
        branch_nxt_s  = branch_r;
        done_nxt_s    = 1'b0;
        illegal_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !launch_shift_s) begin
                    result_nxt_s  = alu_result_s;
                    branch_nxt_s  = alu_branch_s;
                    illegal_nxt_s = alu_illegal_s;
                    done_nxt_s    = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sh_last_s) begin
                    result_nxt_s = sh_data_s;
                    branch_nxt_s = 1'b0;
                    done_nxt_s   = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            default: done_nxt_s = 1'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            result_r  <= {XLEN{1'b0}};
            branch_r  <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            result_r  <= result_nxt_s;
            branch_r  <= branch_nxt_s;
            done_r    <= done_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign result      = result_r;
    assign branchTaken = branch_r;
    assign done        = done_r;
    assign illegal     = illegal_r;
    assign busy        = (state_r != ST_IDLE);

endmodule
